// File: rtl/alu_pkg.sv
// Shared ALU-control constants: aluc codes, aluop bit positions, funct encodings and MDU state type.
// The optional divider is controlled by ALUC_MDU_DIV_EN in the files that import this package.
package alu_pkg;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0100;
    localparam logic [3:0] ALUC_SRA = 4'b0101;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1000;

    localparam int AOP_R   = 0;
    localparam int AOP_ADD = 1;
    localparam int AOP_AND = 2;
    localparam int AOP_OR  = 3;
    localparam int AOP_SUB = 4;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_NOR   = 6'b100111;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

    function automatic logic [3:0] r_decode(input logic [5:0] f);
        case (f)
            F_ADD:   r_decode = ALUC_ADD;
            F_SUB:   r_decode = ALUC_SUB;
            F_AND:   r_decode = ALUC_AND;
            F_OR:    r_decode = ALUC_OR;
            F_SLT:   r_decode = ALUC_SLT;
            F_SLL:   r_decode = ALUC_SLL;
            F_SRL:   r_decode = ALUC_SRL;
            F_SRA:   r_decode = ALUC_SRA;
            F_NOR:   r_decode = ALUC_NOR;
            default: r_decode = ALUC_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per clock over WIDTH cycles.
// The divide step is compiled only when ALUC_MDU_DIV_EN is defined.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               last_o,
    output logic [2*WIDTH-1:0] res_o
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] step_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     mul_sum;

    // acc_q holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};

`ifdef ALUC_MDU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opnd_q};
    assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    assign step_d   = div_q ? {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge}
                            : {mul_sum, acc_q[WIDTH-1:1]};
`else
    logic unused_div;
    assign unused_div = div_i;
    assign step_d     = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    assign busy_o = (state_q == MD_RUN);
    assign last_o = (state_q == MD_RUN) && (cnt_q == CW'(WIDTH - 1));
    assign res_o  = step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        state_q <= MD_RUN;
                        cnt_q   <= '0;
                    end
                end
                MD_RUN: begin
                    cnt_q <= last_o ? '0 : cnt_q + 1'b1;
                    if (last_o) state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start_i && state_q == MD_IDLE) begin
            opnd_q <= div_i ? b_i : a_i;
            acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
`ifdef ALUC_MDU_DIV_EN
            div_q  <= div_i;
`endif
        end else if (state_q == MD_RUN) begin
            acc_q <= step_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode with iterative MDU, HI/LO registers, sign fix-up and hazard stall.
// Define ALUC_MDU_DIV_EN to enable DIV/DIVU; otherwise those functs decode as plain R-type.
module alu_ctrl_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [5:0]         funct,
    input  logic               valid,
    input  logic               flush,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [3:0]         aluc,
    output logic               stall,
    output logic               md_busy,
    output logic               md_done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic issue, is_mul, is_div, is_mthi, is_mtlo, is_mfx, hilo_op, start;
    logic sgn, a_neg, b_neg, neg_q, done_q, md_last;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] res, prod_fix;

    always_comb begin
        aluc = ALUC_ADD;
        if (aluop[AOP_R])        aluc = r_decode(funct);
        else if (aluop[AOP_ADD]) aluc = ALUC_ADD;
        else if (aluop[AOP_AND]) aluc = ALUC_AND;
        else if (aluop[AOP_OR])  aluc = ALUC_OR;
        else if (aluop[AOP_SUB]) aluc = ALUC_SUB;
    end

    assign issue   = valid & ~flush & aluop[AOP_R];
    assign is_mul  = (funct == F_MULT) || (funct == F_MULTU);
`ifdef ALUC_MDU_DIV_EN
    assign is_div  = (funct == F_DIV) || (funct == F_DIVU);
`else
    assign is_div  = 1'b0;
`endif
    assign is_mthi = (funct == F_MTHI);
    assign is_mtlo = (funct == F_MTLO);
    assign is_mfx  = (funct == F_MFHI) || (funct == F_MFLO);
    assign hilo_op = is_mul | is_div | is_mthi | is_mtlo | is_mfx;
    assign stall   = md_busy & issue & hilo_op;
    assign start   = issue & ~md_busy & (is_mul | is_div);

    assign sgn   = (funct == F_MULT) || (is_div && funct == F_DIV);
    assign a_neg = sgn & op_a[WIDTH-1];
    assign b_neg = sgn & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .div_i   (is_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .busy_o  (md_busy),
        .last_o  (md_last),
        .res_o   (res)
    );

    assign prod_fix = neg_q ? -res : res;

`ifdef ALUC_MDU_DIV_EN
    logic div_q, a_neg_q, bzero_q;
    logic [WIDTH-1:0] quo, rem;
    assign quo = res[WIDTH-1:0];
    assign rem = res[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (start) begin
            neg_q   <= a_neg ^ b_neg;
`ifdef ALUC_MDU_DIV_EN
            div_q   <= is_div;
            a_neg_q <= a_neg;
            bzero_q <= (op_b == '0);
`endif
        end
    end

    // A commit and a move never coincide: moves are stalled while the unit is busy
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_last) begin
            {hi_d, lo_d} = prod_fix;
`ifdef ALUC_MDU_DIV_EN
            if (div_q) begin
                lo_d = bzero_q ? '1 : (neg_q ? -quo : quo);
                hi_d = a_neg_q ? -rem : rem;
            end
`endif
        end else if (issue && !md_busy && is_mthi) begin
            hi_d = op_a;
        end else if (issue && !md_busy && is_mtlo) begin
            lo_d = op_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= md_last;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign md_done = done_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed self-checking bench for alu_ctrl_mdu: decode table plus multi-cycle MDU sequences.
// Divide checks adapt to whether ALUC_MDU_DIV_EN is defined.
module tb_alu_ctrl_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [4:0]   aluop;
    logic [5:0]   funct;
    logic         valid, flush;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   aluc;
    logic         stall, md_busy, md_done;
    logic [W-1:0] hi, lo;

    int n_err = 0;
    int n_chk = 0;

    alu_ctrl_mdu #(.WIDTH(W), .ALUOP_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .aluop(aluop), .funct(funct), .valid(valid),
        .flush(flush), .op_a(op_a), .op_b(op_b), .aluc(aluc), .stall(stall),
        .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] aop;
        logic [5:0] fn;
        logic [3:0] exp;
    } dec_vec_t;

    dec_vec_t dv[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int n;
        logic got;
        aluop = 5'b00001; funct = f; op_a = a; op_b = b; valid = 1'b1; flush = 1'b0;
        step();
        chk({nm, "_busy"}, 64'(md_busy), 64'd1);
        valid = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < W + 8) begin
            step();
            n++;
            got = md_done;
        end
        chk({nm, "_cycles"}, 64'(n), 64'(W));
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_idle"}, 64'(md_busy), 64'd0);
        step();
        chk({nm, "_pulse"}, 64'(md_done), 64'd0);
    endtask

    initial begin
        int n;
        logic seen;

        rst_n = 1'b0; aluop = '0; funct = '0; valid = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
        dv[0]  = '{5'b00000, 6'b100010, 4'b0010};
        dv[1]  = '{5'b00010, 6'b100010, 4'b0010};
        dv[2]  = '{5'b00100, 6'b100000, 4'b0000};
        dv[3]  = '{5'b01000, 6'b100000, 4'b0001};
        dv[4]  = '{5'b10000, 6'b100000, 4'b0110};
        dv[5]  = '{5'b00011, 6'b100010, 4'b0110};
        dv[6]  = '{5'b11100, 6'b000000, 4'b0000};
        dv[7]  = '{5'b00001, 6'b100000, 4'b0010};
        dv[8]  = '{5'b00001, 6'b100100, 4'b0000};
        dv[9]  = '{5'b00001, 6'b100101, 4'b0001};
        dv[10] = '{5'b00001, 6'b101010, 4'b0111};
        dv[11] = '{5'b00001, 6'b000000, 4'b0011};
        dv[12] = '{5'b00001, 6'b000010, 4'b0100};
        dv[13] = '{5'b00001, 6'b000011, 4'b0101};
        dv[14] = '{5'b00001, 6'b100111, 4'b1000};

        repeat (2) step();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            aluop = dv[i].aop; funct = dv[i].fn;
            #1;
            chk($sformatf("dec%0d", i), 64'(aluc), 64'(dv[i].exp));
        end
        aluop = 5'b00001; funct = 6'b111111;
        #1;
        chk("dec_other", 64'(aluc), 64'(4'b0010));

        // plain moves
        aluop = 5'b00001; valid = 1'b1; funct = 6'b010001; op_a = 32'h0000_CAFE;
        step();
        chk("mthi", 64'(hi), 64'h0000_CAFE);
        funct = 6'b010011; op_a = 32'h1234_5678;
        step();
        chk("mtlo", 64'(lo), 64'h1234_5678);
        valid = 1'b0;

        run_md("mult", 6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("multu", 6'b011001, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1);

`ifdef ALUC_MDU_DIV_EN
        run_md("divu", 6'b011011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("div_neg", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_md("div_zero", 6'b011010, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
`else
        aluop = 5'b00001; funct = 6'b011010; op_a = 32'd100; op_b = 32'd7; valid = 1'b1;
        #1;
        chk("nodiv_aluc", 64'(aluc), 64'(4'b0010));
        step();
        chk("nodiv_busy", 64'(md_busy), 64'd0);
        funct = 6'b011011;
        step();
        step();
        chk("nodiv_hi", 64'(hi), 64'h0000_0004);
        chk("nodiv_lo", 64'(lo), 64'hFFFF_FFF1);
        valid = 1'b0;
`endif

        // hazard: mult, independent add, flushed mthi, then dependent mflo
        aluop = 5'b00001; funct = 6'b011000; op_a = 32'hFFFF_FFFD; op_b = 32'd5; valid = 1'b1;
        step();
        chk("hz_busy", 64'(md_busy), 64'd1);
        funct = 6'b100000;
        #1;
        chk("hz_add_stall", 64'(stall), 64'd0);
        chk("hz_add_aluc", 64'(aluc), 64'(4'b0010));
        step();
        funct = 6'b010001; flush = 1'b1; op_a = 32'hDEAD_BEEF;
        #1;
        chk("hz_flush_stall", 64'(stall), 64'd0);
        step();
        flush = 1'b0; funct = 6'b010010;
        #1;
        n = 0;
        while (stall && n < W + 8) begin
            step();
            n++;
        end
        chk("hz_stall_len", 64'(n), 64'(W - 2));
        chk("hz_busy_fall", 64'(md_busy), 64'd0);
        chk("hz_lo", 64'(lo), 64'hFFFF_FFF1);
        chk("hz_hi", 64'(hi), 64'hFFFF_FFFF);
        valid = 1'b0;
        step();

        // flushed move while idle must not write
        funct = 6'b010001; op_a = 32'hDEAD_BEEF; valid = 1'b1; flush = 1'b1;
        step();
        chk("flush_nowrite", 64'(hi), 64'hFFFF_FFFF);
        valid = 1'b0; flush = 1'b0;

        // reset in the middle of a run
        aluop = 5'b00001; funct = 6'b011000; op_a = 32'd6; op_b = 32'd7; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (9) step();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_hi", 64'(hi), 64'd0);
        chk("mrst_lo", 64'(lo), 64'd0);
        chk("mrst_busy", 64'(md_busy), 64'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < W + 4; c++) begin
            step();
            seen = seen | md_done | md_busy;
        end
        chk("mrst_no_done", 64'(seen), 64'd0);
        run_md("mult_after", 6'b011000, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
